// File: rtl/bmp_pkg.sv
// bmp_pkg: shared constants, FSM state type and helpers for the BMP stream writer.
//   BMP_HDR_BYTES : size of file header + BITMAPINFOHEADER
//   DIB_SIZE      : BITMAPINFOHEADER size field value
//   BMP_BPP       : bits per pixel emitted (24)
//   BMP_PPM       : pixels per metre (~72 dpi) written to both resolution fields
//   bmp_state_e   : writer FSM states
//   row_bytes()   : row size in bytes padded up to a 4-byte multiple
package bmp_pkg;

    localparam int BMP_HDR_BYTES = 54;
    localparam int DIB_SIZE      = 40;
    localparam int BMP_BPP       = 24;
    localparam int BMP_PPM       = 2835;

    typedef enum logic [2:0] {
        CAPTURE = 3'd0,
        HEADER  = 3'd1,
        PIXELS  = 3'd2,
        PAD     = 3'd3,
        DONE    = 3'd4
    } bmp_state_e;

    function automatic int row_bytes(input int width);
        return ((3 * width + 3) / 4) * 4;
    endfunction

endpackage

// File: rtl/bmp_header_gen.sv
// bmp_header_gen: combinational lookup of BMP header byte by index.
//   idx_i  : byte index 0..53 within the header (values >= 54 give 0x00)
//   byte_o : header byte at that index; all multi-byte fields little-endian
module bmp_header_gen
    import bmp_pkg::*;
#(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512
) (
    input  logic [5:0] idx_i,
    output logic [7:0] byte_o
);

    localparam int IMG_BYTES  = row_bytes(WIDTH) * HEIGHT;
    localparam int FILE_BYTES = BMP_HDR_BYTES + IMG_BYTES;

    logic [5:0]  off_s;
    logic [31:0] field_s;

    // After the two signature bytes every field falls on a 4-byte slot;
    // planes(1) and bpp(24) share one slot as {bpp, planes}.
    always_comb begin
        off_s   = idx_i - 6'd2;
        field_s = 32'd0;
        byte_o  = 8'd0;
        case (off_s[5:2])
            4'd0:    field_s = 32'(FILE_BYTES);
            4'd2:    field_s = 32'(BMP_HDR_BYTES);
            4'd3:    field_s = 32'(DIB_SIZE);
            4'd4:    field_s = 32'(WIDTH);
            4'd5:    field_s = 32'(HEIGHT);
            4'd6:    field_s = {16'(BMP_BPP), 16'd1};
            4'd8:    field_s = 32'(IMG_BYTES);
            4'd9:    field_s = 32'(BMP_PPM);
            4'd10:   field_s = 32'(BMP_PPM);
            default: field_s = 32'd0;
        endcase
        if (idx_i == 6'd0) begin
            byte_o = 8'h42;
        end else if (idx_i == 6'd1) begin
            byte_o = 8'h4D;
        end else if (idx_i < 6'd54) begin
            byte_o = field_s[{off_s[1:0], 3'b000} +: 8];
        end else begin
            byte_o = 8'd0;
        end
    end

endmodule

// File: rtl/bmp_stream_writer.sv
// bmp_stream_writer: captures one RGB888 frame (PIX_PER_CLK pixels per beat)
// into a frame buffer, then streams it out as a 24-bit BMP file.
//   clk, rst_n   : clock, asynchronous active-low reset
//   s_valid/s_ready/s_data/s_last : pixel input beats, s_last on row end
//   m_valid/m_ready/m_data/m_last : output byte stream, m_last on final byte
//   frame_done   : one-cycle pulse after the final byte is accepted
//   line_err     : sticky row-framing error, cleared on next frame's first beat
//   frame_count  : completed frames (wrapping)
module bmp_stream_writer
    import bmp_pkg::*;
#(
    parameter int WIDTH       = 768,
    parameter int HEIGHT      = 512,
    parameter int PIX_PER_CLK = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [24*PIX_PER_CLK-1:0]  s_data,
    input  logic                       s_last,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [7:0]                 m_data,
    output logic                       m_last,
    output logic                       frame_done,
    output logic                       line_err,
    output logic [15:0]                frame_count
);

    localparam int BEATS_PER_ROW = WIDTH / PIX_PER_CLK;
    localparam int DEPTH         = WIDTH * HEIGHT / PIX_PER_CLK;
    localparam int PAD_BYTES     = row_bytes(WIDTH) - 3 * WIDTH;
    localparam int AW            = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW            = $clog2(WIDTH + 1);
    localparam int RW            = $clog2(HEIGHT + 1);
    localparam int DW            = 24 * PIX_PER_CLK;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_word_q;

    bmp_state_e    state_q, state_d;
    logic [5:0]    hdr_idx_q, hdr_idx_d;
    logic [RW-1:0] orow_q, orow_d;
    logic [CW-1:0] opix_q, opix_d;
    logic [1:0]    bsel_q, bsel_d;
    logic [1:0]    pad_q, pad_d;

    logic [AW-1:0] wr_addr_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;

    logic          s_ready_q, m_valid_q, m_last_q, frame_done_q, line_err_q;
    logic [7:0]    m_data_q;
    logic [15:0]   frame_count_q;

    logic          beat_s, last_col_s, last_beat_s, ld_s, done_s;
    logic          gen_ld_s, gen_last_s;
    logic [7:0]    gen_byte_s, hdr_byte_s, pix_byte_s;
    logic [23:0]   pix_s;
    logic [AW-1:0] rd_addr_s;
    int            lane_s;

    bmp_header_gen #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_hdr (
        .idx_i  (hdr_idx_q),
        .byte_o (hdr_byte_s)
    );

    assign beat_s      = s_valid && s_ready_q;
    assign last_col_s  = (col_q == CW'(WIDTH - PIX_PER_CLK));
    assign last_beat_s = last_col_s && (row_q == RW'(HEIGHT - 1));
    // Output register may take a new byte when empty or being drained.
    assign ld_s        = !m_valid_q || m_ready;
    assign done_s      = (state_q == DONE) && m_valid_q && m_ready;

    // Byte-lane mux: pick the pixel within the buffered word, then B/G/R.
    always_comb begin
        lane_s     = int'(opix_q) % PIX_PER_CLK;
        pix_s      = rd_word_q[24*lane_s +: 24];
        pix_byte_s = pix_s[{bsel_q, 3'b000} +: 8];
    end

    // Output sequencer next state: which byte goes out next and where the
    // counters move. DONE holds the final byte until it is accepted.
    always_comb begin
        state_d    = state_q;
        hdr_idx_d  = hdr_idx_q;
        orow_d     = orow_q;
        opix_d     = opix_q;
        bsel_d     = bsel_q;
        pad_d      = pad_q;
        gen_ld_s   = 1'b0;
        gen_last_s = 1'b0;
        gen_byte_s = 8'd0;
        case (state_q)
            CAPTURE: begin
                // Header byte 0 is loaded with the final beat so the stream
                // starts on the very next cycle.
                if (beat_s && last_beat_s) begin
                    state_d    = HEADER;
                    hdr_idx_d  = 6'd1;
                    gen_ld_s   = 1'b1;
                    gen_byte_s = hdr_byte_s;
                end else begin
                    state_d = CAPTURE;
                end
            end
            HEADER: begin
                if (ld_s) begin
                    gen_ld_s   = 1'b1;
                    gen_byte_s = hdr_byte_s;
                    if (hdr_idx_q == 6'd53) begin
                        state_d   = PIXELS;
                        hdr_idx_d = 6'd0;
                        orow_d    = RW'(HEIGHT - 1);
                        opix_d    = '0;
                        bsel_d    = 2'd0;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 6'd1;
                    end
                end else begin
                    state_d = HEADER;
                end
            end
            PIXELS: begin
                if (ld_s) begin
                    gen_ld_s   = 1'b1;
                    gen_byte_s = pix_byte_s;
                    if (bsel_q != 2'd2) begin
                        bsel_d = bsel_q + 2'd1;
                    end else if (opix_q != CW'(WIDTH - 1)) begin
                        bsel_d = 2'd0;
                        opix_d = opix_q + CW'(1);
                    end else begin
                        bsel_d = 2'd0;
                        opix_d = '0;
                        if (PAD_BYTES != 0) begin
                            state_d = PAD;
                            pad_d   = 2'd0;
                        end else if (orow_q == '0) begin
                            state_d    = DONE;
                            gen_last_s = 1'b1;
                        end else begin
                            orow_d = orow_q - RW'(1);
                        end
                    end
                end else begin
                    state_d = PIXELS;
                end
            end
            PAD: begin
                if (ld_s) begin
                    gen_ld_s   = 1'b1;
                    gen_byte_s = 8'd0;
                    if (pad_q != 2'(PAD_BYTES - 1)) begin
                        pad_d = pad_q + 2'd1;
                    end else if (orow_q == '0) begin
                        pad_d      = 2'd0;
                        state_d    = DONE;
                        gen_last_s = 1'b1;
                    end else begin
                        pad_d   = 2'd0;
                        state_d = PIXELS;
                        orow_d  = orow_q - RW'(1);
                    end
                end else begin
                    state_d = PAD;
                end
            end
            DONE: begin
                if (done_s) begin
                    state_d = CAPTURE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = CAPTURE;
        endcase
    end

    // Prefetch address follows the next-state counters so rd_word_q always
    // holds the word for the current output pixel.
    always_comb begin
        rd_addr_s = AW'(int'(orow_d) * BEATS_PER_ROW + int'(opix_d) / PIX_PER_CLK);
    end

    // Frame buffer: write during capture, registered read every cycle.
    always_ff @(posedge clk) begin
        if (beat_s) begin
            mem_q[wr_addr_q] <= s_data;
        end
        rd_word_q <= mem_q[rd_addr_s];
    end

    // FSM, capture counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= CAPTURE;
            hdr_idx_q     <= 6'd0;
            orow_q        <= '0;
            opix_q        <= '0;
            bsel_q        <= 2'd0;
            pad_q         <= 2'd0;
            wr_addr_q     <= '0;
            col_q         <= '0;
            row_q         <= '0;
            s_ready_q     <= 1'b1;
            m_valid_q     <= 1'b0;
            m_data_q      <= 8'd0;
            m_last_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            line_err_q    <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            hdr_idx_q    <= hdr_idx_d;
            orow_q       <= orow_d;
            opix_q       <= opix_d;
            bsel_q       <= bsel_d;
            pad_q        <= pad_d;
            s_ready_q    <= (state_d == CAPTURE);
            frame_done_q <= done_s;
            if (done_s) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
            if (gen_ld_s) begin
                m_valid_q <= 1'b1;
                m_data_q  <= gen_byte_s;
                m_last_q  <= gen_last_s;
            end else if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end
            if (beat_s) begin
                // The first beat of a frame restarts the sticky error.
                if (wr_addr_q == '0) begin
                    line_err_q <= (s_last != last_col_s);
                end else if (s_last != last_col_s) begin
                    line_err_q <= 1'b1;
                end
                if (last_beat_s) begin
                    wr_addr_q <= '0;
                    col_q     <= '0;
                    row_q     <= '0;
                end else if (last_col_s) begin
                    wr_addr_q <= wr_addr_q + AW'(1);
                    col_q     <= '0;
                    row_q     <= row_q + RW'(1);
                end else begin
                    wr_addr_q <= wr_addr_q + AW'(1);
                    col_q     <= col_q + CW'(PIX_PER_CLK);
                end
            end
        end
    end

    assign s_ready     = s_ready_q;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_last      = m_last_q;
    assign frame_done  = frame_done_q;
    assign line_err    = line_err_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_bmp_stream_writer.sv
// tb_bmp_stream_writer: randomized self-checking bench for bmp_stream_writer.
// Two instances: A = 4x2 @ 2 pix/clk (no padding), B = 3x2 @ 1 pix/clk (3 pad bytes).
// Expected byte streams come from a file-level BMP model built with queues.
module tb_bmp_stream_writer;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last  = 1'b0;
    logic        mready   = 1'b0;
    logic [47:0] in_data  = 48'd0;
    logic        sel      = 1'b0;

    logic a_ready, a_mvalid, a_mlast, a_done, a_lerr;
    logic b_ready, b_mvalid, b_mlast, b_done, b_lerr;
    logic [7:0]  a_mdata, b_mdata;
    logic [15:0] a_fcnt, b_fcnt;

    bmp_stream_writer #(.WIDTH(4), .HEIGHT(2), .PIX_PER_CLK(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .s_valid(in_valid & ~sel), .s_ready(a_ready), .s_data(in_data), .s_last(in_last),
        .m_valid(a_mvalid), .m_ready(mready), .m_data(a_mdata), .m_last(a_mlast),
        .frame_done(a_done), .line_err(a_lerr), .frame_count(a_fcnt)
    );

    bmp_stream_writer #(.WIDTH(3), .HEIGHT(2), .PIX_PER_CLK(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .s_valid(in_valid & sel), .s_ready(b_ready), .s_data(in_data[23:0]), .s_last(in_last),
        .m_valid(b_mvalid), .m_ready(mready), .m_data(b_mdata), .m_last(b_mlast),
        .frame_done(b_done), .line_err(b_lerr), .frame_count(b_fcnt)
    );

    wire        o_ready  = sel ? b_ready  : a_ready;
    wire        o_mvalid = sel ? b_mvalid : a_mvalid;
    wire        o_mlast  = sel ? b_mlast  : a_mlast;
    wire        o_done   = sel ? b_done   : a_done;
    wire        o_lerr   = sel ? b_lerr   : a_lerr;
    wire [7:0]  o_mdata  = sel ? b_mdata  : a_mdata;
    wire [15:0] o_fcnt   = sel ? b_fcnt   : a_fcnt;

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         pix_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // pattern: (R,G,B) = (n, n+16, n+32); otherwise random RGB888
    task automatic make_pix(input int n, input bit pattern);
        pix_q.delete();
        for (int i = 0; i < n; i++) begin
            if (pattern) pix_q.push_back((i << 16) | ((i + 16) << 8) | (i + 32));
            else         pix_q.push_back(int'($urandom & 32'h00FF_FFFF));
        end
    endtask

    task automatic put_le(input int v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(8'((v >> (8 * i)) & 255));
    endtask

    // Reference BMP file: header, rows bottom-up, BGR, zero padding to 4 bytes.
    task automatic build_exp(input int w, input int h);
        int rb, img, p;
        rb  = ((3 * w + 3) / 4) * 4;
        img = rb * h;
        exp_q.delete();
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h4D);
        put_le(54 + img, 4); put_le(0, 4); put_le(54, 4);
        put_le(40, 4); put_le(w, 4); put_le(h, 4); put_le(1, 2); put_le(24, 2);
        put_le(0, 4); put_le(img, 4); put_le(2835, 4); put_le(2835, 4); put_le(0, 4); put_le(0, 4);
        for (int r = h - 1; r >= 0; r--) begin
            for (int c = 0; c < w; c++) begin
                p = pix_q[r * w + c];
                exp_q.push_back(8'(p));
                exp_q.push_back(8'(p >> 8));
                exp_q.push_back(8'(p >> 16));
            end
            for (int k = 3 * w; k < rb; k++) exp_q.push_back(8'd0);
        end
    endtask

    task automatic send_frame(input int w, input int h, input int ppc, input bit bad);
        int nb, to;
        nb = w * h / ppc;
        for (int b = 0; b < nb; b++) begin
            to = 0;
            while (!o_ready && to < 200) begin
                @(negedge clk);
                to++;
            end
            if (to >= 200) begin
                chk("s_ready_timeout", 32'(o_ready), 32'd1);
                break;
            end
            in_valid = 1'b1;
            in_data  = 48'd0;
            for (int j = 0; j < ppc; j++) in_data[24*j +: 24] = 24'(pix_q[b * ppc + j]);
            in_last  = ((b % (w / ppc)) == (w / ppc - 1)) || (bad && b == 0);
            @(negedge clk);
            if (b == 0) chk("line_err_beat0", 32'(o_lerr), 32'(bad));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic collect(input int nbytes, input bit rnd);
        int         cyc;
        bit         stall;
        logic [7:0] hd;
        logic       hl;
        cyc   = 0;
        stall = 1'b0;
        hd    = 8'd0;
        hl    = 1'b0;
        got_q.delete();
        chk("first_hdr_valid", 32'(o_mvalid), 32'd1);
        while (got_q.size() < nbytes && cyc < 3000) begin
            if (stall) begin
                chk("stall_valid", 32'(o_mvalid), 32'd1);
                chk("stall_data", 32'(o_mdata), 32'(hd));
                chk("stall_last", 32'(o_mlast), 32'(hl));
            end
            chk("s_ready_in_output", 32'(o_ready), 32'd0);
            mready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (o_mvalid && mready) begin
                chk("m_last", 32'(o_mlast), 32'(got_q.size() == exp_q.size() - 1));
                got_q.push_back(o_mdata);
            end
            stall = o_mvalid && !mready;
            hd    = o_mdata;
            hl    = o_mlast;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 3000) chk("collect_timeout", 32'(got_q.size()), 32'(nbytes));
    endtask

    task automatic run_frame(input int w, input int h, input int ppc, input bit bad,
                             input bit rnd, input int fc);
        send_frame(w, h, ppc, bad);
        collect(exp_q.size(), rnd);
        chk("byte_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        chk("frame_done", 32'(o_done), 32'd1);
        chk("s_ready_after", 32'(o_ready), 32'd1);
        chk("m_valid_after", 32'(o_mvalid), 32'd0);
        chk("frame_count", 32'(o_fcnt), 32'(fc));
        @(negedge clk);
        chk("frame_done_pulse", 32'(o_done), 32'd0);
    endtask

    task automatic reset_checks();
        chk("rst_s_ready", 32'(o_ready), 32'd1);
        chk("rst_m_valid", 32'(o_mvalid), 32'd0);
        chk("rst_m_data", 32'(o_mdata), 32'd0);
        chk("rst_m_last", 32'(o_mlast), 32'd0);
        chk("rst_frame_done", 32'(o_done), 32'd0);
        chk("rst_line_err", 32'(o_lerr), 32'd0);
        chk("rst_frame_count", 32'(o_fcnt), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_checks();
        rst_n = 1'b1;
        @(negedge clk);

        // Known pattern, m_ready held high.
        make_pix(8, 1'b1);
        build_exp(4, 2);
        run_frame(4, 2, 2, 1'b0, 1'b0, 1);
        if (got_q.size() >= 78) begin
            chk("file_size_b2", 32'(got_q[2]), 32'h4E);
            chk("file_size_b3", 32'(got_q[3]), 32'h00);
            chk("file_size_b4", 32'(got_q[4]), 32'h00);
            chk("file_size_b5", 32'(got_q[5]), 32'h00);
            chk("img_bytes_b34", 32'(got_q[34]), 32'h18);
            chk("first_pix_B", 32'(got_q[54]), 32'd36);
            chk("first_pix_G", 32'(got_q[55]), 32'd20);
            chk("first_pix_R", 32'(got_q[56]), 32'd4);
        end

        // Same frame back-to-back under random backpressure.
        run_frame(4, 2, 2, 1'b0, 1'b1, 2);

        // Framing error on beat 0 of row 0: image unchanged, flag sticky.
        make_pix(8, 1'b0);
        build_exp(4, 2);
        run_frame(4, 2, 2, 1'b1, 1'b1, 3);
        chk("line_err_sticky", 32'(o_lerr), 32'd1);

        // Clean frame clears the flag on its first beat.
        make_pix(8, 1'b0);
        build_exp(4, 2);
        run_frame(4, 2, 2, 1'b0, 1'b1, 4);

        // Reset in the middle of the output stream.
        make_pix(8, 1'b0);
        build_exp(4, 2);
        send_frame(4, 2, 2, 1'b1);
        collect(20, 1'b0);
        rst_n = 1'b0;
        #1;
        reset_checks();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        reset_checks();
        make_pix(8, 1'b0);
        build_exp(4, 2);
        run_frame(4, 2, 2, 1'b0, 1'b0, 1);

        // Padded geometry on the second instance.
        sel = 1'b1;
        @(negedge clk);
        make_pix(6, 1'b0);
        build_exp(3, 2);
        run_frame(3, 2, 1, 1'b0, 1'b0, 1);
        if (got_q.size() >= 78) begin
            for (int i = 63; i <= 65; i++) chk($sformatf("pad_row1_%0d", i), 32'(got_q[i]), 32'd0);
            for (int i = 75; i <= 77; i++) chk($sformatf("pad_row0_%0d", i), 32'(got_q[i]), 32'd0);
        end
        make_pix(6, 1'b0);
        build_exp(3, 2);
        run_frame(3, 2, 1, 1'b0, 1'b1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
